// File: rtl/sliding_avg_pkg.sv
// sliding_avg_pkg: window sizing constants and sum/average helpers for sliding_avg.
// SLIDING_AVG_ROUND_EN selects round-half-up with saturation in avg_shift.
package sliding_avg_pkg;
  localparam int IN_W = 6;
  localparam int LOG2_DEPTH = 2;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = IN_W + LOG2_DEPTH;
  localparam int PTR_W = LOG2_DEPTH;
  localparam int FILL_W = LOG2_DEPTH + 1;
  localparam logic signed [SUM_W:0] MAX_AVG = (SUM_W + 1)'((1 << (IN_W - 1)) - 1);
  function automatic logic signed [SUM_W-1:0] sext_sum(input logic [IN_W-1:0] d);
    return {{LOG2_DEPTH{d[IN_W-1]}}, d};
  endfunction
  function automatic logic [IN_W-1:0] avg_shift(input logic signed [SUM_W-1:0] s);
`ifdef SLIDING_AVG_ROUND_EN
    logic signed [SUM_W:0] r;
    r = $signed({s[SUM_W-1], s}) + (SUM_W + 1)'(DEPTH / 2);
    r = r >>> LOG2_DEPTH;
    return (r > MAX_AVG) ? IN_W'(MAX_AVG) : IN_W'(r);
`else
    return IN_W'(s >>> LOG2_DEPTH);
`endif
  endfunction
endpackage

// File: rtl/sliding_avg_win_buf.sv
// win_buf: circular sample store; rdata is the entry at wr_ptr before this cycle's write.
module win_buf #(
  parameter int IN_W = 6,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IN_W-1:0] wdata,
  output logic [IN_W-1:0] rdata
);
  logic [IN_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  assign rdata = mem[wr_ptr];
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
endmodule

// File: rtl/sliding_avg.sv
// sliding_avg: moving average over the last DEPTH accepted samples; SLIDING_AVG_ROUND_EN enables rounding.
module sliding_avg #(
  parameter int IN_W = sliding_avg_pkg::IN_W,
  parameter int LOG2_DEPTH = sliding_avg_pkg::LOG2_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [IN_W-1:0] i_data,
  input  logic            i_valid,
  output logic [IN_W-1:0] o_data,
  output logic            o_ready,
  output logic            o_full
);
  import sliding_avg_pkg::*;
  logic signed [SUM_W-1:0] sum, new_sum;
  logic [FILL_W-1:0] fill, new_fill;
  logic [IN_W-1:0] old;
  logic full_now;
  win_buf #(.IN_W(IN_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_buf (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .we(i_valid),
    .wdata(i_data),
    .rdata(old)
  );
  // the evicted entry is still zero during the initial fill, so one update rule covers both phases
  assign new_sum = sum + sext_sum(i_data) - sext_sum(old);
  assign new_fill = (fill == FILL_W'(DEPTH)) ? fill : fill + 1'b1;
  assign full_now = new_fill == FILL_W'(DEPTH);
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      sum <= '0;
      fill <= '0;
      o_data <= '0;
      o_ready <= 1'b0;
      o_full <= 1'b0;
    end else begin
      o_ready <= i_valid && full_now;
      if (i_valid) begin
        sum <= new_sum;
        fill <= new_fill;
        if (full_now) begin
          o_data <= avg_shift(new_sum);
          o_full <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_sliding_avg.sv
// tb_sliding_avg: directed checks of fill latency, wrap, extremes, rounding, gaps and reset.
module tb_sliding_avg;
`ifdef SLIDING_AVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [5:0] i_data = '0;
  logic i_valid = 1'b0;
  logic [5:0] o_data;
  logic o_ready, o_full;
  int total = 0;
  int bad = 0;
  int hold = 0;

  sliding_avg dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_data(o_data),
    .o_ready(o_ready),
    .o_full(o_full)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_out(input bit rdy, input bit full);
    chk("o_ready", int'(o_ready), int'(rdy));
    chk("o_data", int'($signed(o_data)), hold);
    chk("o_full", int'(o_full), int'(full));
  endtask

  task automatic step(input bit v, input int d, input bit rdy, input int avg, input bit full);
    @(negedge i_clk);
    i_valid = v;
    i_data = d[5:0];
    @(posedge i_clk);
    #1;
    if (rdy) hold = avg;
    check_out(rdy, full);
  endtask

  initial begin
    i_rst_n = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    check_out(1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(1, 4, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    step(1, 4, 1, 4, 1);
    step(1, 8, 1, 5, 1);
    step(1, 8, 1, 6, 1);
    step(1, 8, 1, 7, 1);
    step(1, 8, 1, 8, 1);
    step(1, -32, 1, -2, 1);
    step(1, -32, 1, -12, 1);
    step(1, -32, 1, -22, 1);
    step(1, -32, 1, -32, 1);
    step(1, 31, 1, RND ? -16 : -17, 1);
    step(1, 31, 1, RND ? 0 : -1, 1);
    step(1, 31, 1, 15, 1);
    step(1, 31, 1, 31, 1);
    step(1, -1, 1, 23, 1);
    step(1, -1, 1, 15, 1);
    step(1, 0, 1, 7, 1);
    step(1, 0, 1, RND ? 0 : -1, 1);
    step(1, 1, 1, 0, 1);
    step(1, 1, 1, RND ? 1 : 0, 1);
    step(1, 1, 1, RND ? 1 : 0, 1);
    step(0, 17, 0, 0, 1);
    step(1, 0, 1, RND ? 1 : 0, 1);
    // restart empty, then feed samples with junk on the idle cycles
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    hold = 0;
    step(1, 3, 0, 0, 0);
    step(0, 31, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(0, -32, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(0, 21, 0, 0, 0);
    step(1, 3, 1, 3, 1);
    step(0, 31, 0, 0, 1);
    // reset wins over a valid sample in the same cycle
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_data = 6'd20;
    @(posedge i_clk);
    #1;
    hold = 0;
    check_out(1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    step(1, 5, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 5, 1, 5, 1);
    @(negedge i_clk);
    i_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
